toggle_detector: RTL and testbench
==================================

TOGGLE_DETECTOR -- requirements
Module: toggle_detector

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning cycles without a detected edge before stall is flagged (legal range 2..255).
REQ-002 Parameter CNT_W, default 4, meaning width of the edge counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 eneable  input  1  active-high enable; low freezes detection state.
REQ-006 t_in  input  1  asynchronous toggle line (e.g. divide-by-2 flip-flop output) to be decoded.
REQ-007 clr  input  1  synchronous clear of count and overflow.
REQ-008 pulse  output  1  one-cycle strobe per detected t_in edge.
REQ-009 rise  output  1  one-cycle strobe, high with pulse when the detected edge is 0->1.
REQ-010 level  output  1  synchronized, registered copy of t_in.
REQ-011 count  output  CNT_W  detected-edge counter.
REQ-012 overflow  output  1  sticky flag, set when count wraps.
REQ-013 stall  output  1  high while the FSM is in STALL.

Function
REQ-014 t_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a history flop s3; level SHALL equal s3.
REQ-015 edge is defined as s2 XOR s3; rise_edge as s2 AND NOT s3.
REQ-016 pulse SHALL be registered: pulse <= edge AND eneable; rise <= rise_edge AND eneable.
REQ-017 Latency: a t_in change captured into s1 at clock edge k SHALL produce pulse high for exactly the cycle after edge k+2, i.e. 3 clock edges.
REQ-018 The synchronizer and s3 SHALL run regardless of eneable; edges occurring while eneable=0 are dropped, never reported later.
REQ-019 Each qualified edge (edge AND eneable) SHALL increment count by 1 modulo 2^CNT_W.
REQ-020 On increment from 2^CNT_W-1 to 0, overflow SHALL be set and SHALL hold until clr or reset.
REQ-021 clr=1 SHALL force count to 0 and overflow to 0 on the next edge; clr has priority over a simultaneous qualified edge (that edge is not counted, but pulse/rise are still emitted).
REQ-022 FSM states: IDLE (no edge yet seen), TRACK (edges arriving), STALL (timeout reached).
REQ-023 IDLE -> TRACK on a qualified edge; timer cleared to 0; IDLE never times out.
REQ-024 In TRACK the timer SHALL increment each enabled cycle without a qualified edge; a qualified edge clears it to 0.
REQ-025 TRACK -> STALL when the timer equals TIMEOUT-1 and no qualified edge occurs in that cycle; stall SHALL be 1 in the cycle after the transition edge.
REQ-026 STALL -> TRACK on a qualified edge, timer cleared, stall deasserted on the same clock edge that registers pulse.
REQ-027 Timer and FSM state SHALL freeze while eneable=0.
REQ-028 The timer SHALL saturate and never wrap; its width SHALL be ceil(log2(TIMEOUT))+1 bits.
REQ-029 clr SHALL NOT affect FSM state, timer, or synchronizer.

Reset
REQ-030 With reset=0 at a rising clk edge: s1, s2, s3, level, pulse, rise, count, overflow, stall = 0; timer = 0; state = IDLE.
REQ-031 Reset asserted mid-operation SHALL take effect on the next clk edge regardless of eneable, clr, or t_in; no pulse SHALL be emitted in the cycle following reset release unless an edge is newly synchronized.
REQ-032 Reset has priority over all other inputs.

Verification
REQ-033 Reset then t_in 0->1 at cycle 2, eneable=1 -> pulse=1 and rise=1 for one cycle at cycle 5, count=1, level=1, state TRACK.
REQ-034 t_in driven by a divide-by-2 flip-flop toggling every 5 cycles for 16 toggles -> 16 pulses, count wraps to 0, overflow=1; clr pulse -> count=0, overflow=0.
REQ-035 One edge then t_in static, TIMEOUT=16 -> stall=1 exactly 16 cycles after the pulse cycle; next toggle -> pulse, stall=0, count incremented.
REQ-036 eneable=0 during two t_in toggles, then eneable=1 -> no pulse, count unchanged, level tracks t_in, timer resumes from frozen value.
REQ-037 clr asserted in the same cycle as a qualified edge with count=7 -> pulse=1, count=0.
REQ-038 reset=0 for one cycle while in STALL with count=9, overflow=1 -> all outputs 0, state IDLE; no stall afterwards without a new edge.

Source files
------------

// File: rtl/toggle_detector.sv
`default_nettype none
// ============================================================================
// Module  : toggle_detector
// Brief   : Synchronizes a toggle line, strobes each edge, counts edges and
//           flags a stall when edges stop arriving.
// Revision: 1.0
// ============================================================================
module toggle_detector #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eneable,
    input  logic             t_in,
    input  logic             clr,
    output logic             pulse,
    output logic             rise,
    output logic             level,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             stall
);

    localparam int                TMR_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] c_TMR_END = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_pulse;
    logic             r_rise;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_stall;

    logic w_edge;
    logic w_rise_edge;
    logic w_qual;

    assign w_edge      = r_s2 ^ r_s3;
    assign w_rise_edge = r_s2 & ~r_s3;
    assign w_qual      = w_edge & eneable;

    // Synchronizer, history flop and edge strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pulse <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_s1    <= t_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pulse <= w_qual;
            r_rise  <= w_rise_edge & eneable;
        end
    end

    // Edge counter; clear wins over a simultaneous qualified edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_qual) begin
            r_count <= r_count + 1'b1;
            if (r_count == {CNT_W{1'b1}}) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_stall <= 1'b0;
        end else if (eneable) begin
            case (r_state)
                IDLE: begin
                    if (w_qual) begin
                        r_state <= TRACK;
                        r_timer <= '0;
                    end
                end
                TRACK: begin
                    if (w_qual) begin
                        r_timer <= '0;
                    end else if (r_timer == c_TMR_END) begin
                        r_state <= STALL;
                        r_stall <= 1'b1;
                    end else if (r_timer != {TMR_W{1'b1}}) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                STALL: begin
                    if (w_qual) begin
                        r_state <= TRACK;
                        r_timer <= '0;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign pulse    = r_pulse;
    assign rise     = r_rise;
    assign level    = r_s3;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign stall    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_toggle_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_toggle_detector
// Brief   : Directed self-checking bench for toggle_detector (TIMEOUT=16, CNT_W=4).
// Revision: 1.0
// ============================================================================
module tb_toggle_detector;

    logic       clk;
    logic       reset;
    logic       eneable;
    logic       t_in;
    logic       clr;
    logic       pulse;
    logic       rise;
    logic       level;
    logic [3:0] count;
    logic       overflow;
    logic       stall;

    int checks   = 0;
    int failures = 0;

    toggle_detector #(
        .TIMEOUT(16),
        .CNT_W  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .eneable (eneable),
        .t_in    (t_in),
        .clr     (clr),
        .pulse   (pulse),
        .rise    (rise),
        .level   (level),
        .count   (count),
        .overflow(overflow),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        eneable = 1'b1;
        t_in    = 1'b0;
        clr     = 1'b0;
        tick(3);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_stall", 32'(stall), 0);
        reset = 1'b1;
        tick(1);
        chk("post_rst_pulse", 32'(pulse), 0);

        // First rising edge: three clock edges of latency
        t_in = 1'b1;
        tick(2);
        chk("lat_early_pulse", 32'(pulse), 0);
        tick(1);
        chk("lat_pulse", 32'(pulse), 1);
        chk("lat_rise", 32'(rise), 1);
        chk("lat_count", 32'(count), 1);
        chk("lat_level", 32'(level), 1);

        // Stall 16 cycles after the pulse cycle
        tick(15);
        chk("stall_pre", 32'(stall), 0);
        chk("one_pulse_only", 32'(pulse), 0);
        tick(1);
        chk("stall_set", 32'(stall), 1);
        t_in = 1'b0;
        tick(3);
        chk("stall_exit_pulse", 32'(pulse), 1);
        chk("stall_exit_rise", 32'(rise), 0);
        chk("stall_exit_stall", 32'(stall), 0);
        chk("stall_exit_count", 32'(count), 2);

        // Disabled edges are dropped; timer freezes at 3
        tick(3);
        eneable = 1'b0;
        t_in = 1'b1;
        tick(4);
        chk("dis_pulse_a", 32'(pulse), 0);
        chk("dis_level_a", 32'(level), 1);
        t_in = 1'b0;
        tick(4);
        chk("dis_pulse_b", 32'(pulse), 0);
        chk("dis_level_b", 32'(level), 0);
        chk("dis_count", 32'(count), 2);
        eneable = 1'b1;
        tick(12);
        chk("resume_stall_pre", 32'(stall), 0);
        tick(1);
        chk("resume_stall_set", 32'(stall), 1);

        // clr leaves FSM alone
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_count", 32'(count), 0);
        chk("clr_stall_kept", 32'(stall), 1);

        // 16 toggles wrap the counter
        for (int i = 0; i < 16; i++) begin
            t_in = ~t_in;
            tick(3);
            chk("wrap_pulse", 32'(pulse), 1);
            chk("wrap_count", 32'(count), 32'((i + 1) % 16));
            chk("wrap_ovf", 32'(overflow), (i == 15) ? 32'd1 : 32'd0);
            tick(2);
        end
        chk("wrap_stall", 32'(stall), 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("wrap_clr_count", 32'(count), 0);
        chk("wrap_clr_ovf", 32'(overflow), 0);

        // clr coincident with a qualified edge at count=7
        for (int i = 0; i < 7; i++) begin
            t_in = ~t_in;
            tick(5);
        end
        chk("pre_clr7_count", 32'(count), 7);
        t_in = ~t_in;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_edge_pulse", 32'(pulse), 1);
        chk("clr_edge_count", 32'(count), 0);
        tick(2);

        // Reach STALL with count=9 and overflow set, then reset
        for (int i = 0; i < 25; i++) begin
            t_in = ~t_in;
            tick(5);
        end
        eneable = 1'b0;
        t_in = 1'b0;
        tick(4);
        eneable = 1'b1;
        tick(20);
        chk("pre_rst_count", 32'(count), 9);
        chk("pre_rst_ovf", 32'(overflow), 1);
        chk("pre_rst_stall", 32'(stall), 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_level", 32'(level), 0);
        tick(20);
        chk("idle_no_stall", 32'(stall), 0);
        chk("idle_no_pulse", 32'(pulse), 0);
        chk("idle_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
